ack_bus_requester: RTL and testbench

//  Per-module front end of the shared open-drain ACK bus, one instance per source (ctrl/aes/sha/mem).

---
 rtl/ack_bus_requester.sv | 145 ++++++++++++++
 tb/tb_ack_bus_requester.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ack_bus_requester.sv
// rtl/ack_bus_requester.sv - per-source ACK bus front end: event queue, MSB-first wired-AND arbitration, HOLD timeout under ACK_TIMEOUT_EN
module ack_bus_requester #(
   parameter logic [1:0]  SOURCE_ID      = 2'b10,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ack_pulse,
   input  logic       ack_valid_n_bus,
   input  logic [1:0] ack_id_bus,
   input  logic       ack_ready,
   output logic       ack_valid_n_oe,
   output logic [1:0] ack_id_oe,
   output logic       req,
   output logic       ack_done,
   output logic [1:0] pend_cnt,
   output logic       overflow,
   output logic       timeout_err
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARB_MSB,
      S_ARB_LSB,
      S_HOLD,
      S_RELEASE,
      S_BACKOFF
   } state_t;

   state_t     state;
   state_t     state_nx;
   logic       lost_msb;
   logic       lost_lsb;
   logic       deliver;
   logic       tmo_hit;
   logic [1:0] pend_nx;
   logic       ovf_set;
   logic       drive_nx;
   logic       drive_lsb_nx;

   // A source whose ID bit is 1 releases that line; seeing it low means a lower ID is competing.
   assign lost_msb = SOURCE_ID[1] & ~ack_id_bus[1];
   assign lost_lsb = SOURCE_ID[0] & ~ack_id_bus[0];
   assign deliver  = (state == S_HOLD) && !lost_lsb && ack_ready;

`ifdef ACK_TIMEOUT_EN
   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

   logic [7:0] tmo_cnt;

   assign tmo_hit = (state == S_HOLD) && !lost_lsb && !ack_ready && (tmo_cnt == TMO_LAST);

   // Held at zero outside HOLD so every HOLD entry starts a fresh count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tmo_cnt <= 8'd0;
      end else if (state != S_HOLD) begin
         tmo_cnt <= 8'd0;
      end else if (!ack_ready) begin
         tmo_cnt <= tmo_cnt + 8'd1;
      end
   end
`else
   assign tmo_hit = 1'b0 && (TIMEOUT_CYCLES != 0);
`endif

   always_comb begin
      pend_nx = pend_cnt;
      ovf_set = 1'b0;
      if (ack_pulse && !deliver) begin
         if (pend_cnt == 2'd3) begin
            ovf_set = 1'b1;
         end else begin
            pend_nx = pend_cnt + 2'd1;
         end
      end else if (!ack_pulse && deliver) begin
         pend_nx = pend_cnt - 2'd1;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE: begin
            if ((pend_nx != 2'd0) && ack_valid_n_bus) begin
               state_nx = S_ARB_MSB;
            end
         end
         S_ARB_MSB: begin
            state_nx = lost_msb ? S_BACKOFF : S_ARB_LSB;
         end
         S_ARB_LSB: begin
            state_nx = (lost_msb || lost_lsb) ? S_BACKOFF : S_HOLD;
         end
         S_HOLD: begin
            if (lost_lsb) begin
               state_nx = S_BACKOFF;
            end else if (ack_ready) begin
               state_nx = S_RELEASE;
            end else if (tmo_hit) begin
               state_nx = S_BACKOFF;
            end
         end
         S_RELEASE: begin
            state_nx = S_IDLE;
         end
         S_BACKOFF: begin
            if (ack_valid_n_bus) begin
               state_nx = S_IDLE;
            end
         end
         default: begin
            state_nx = S_IDLE;
         end
      endcase
   end

   // Drivers are registered from the next state so they line up with the state they belong to.
   assign drive_nx     = (state_nx == S_ARB_MSB) || (state_nx == S_ARB_LSB) || (state_nx == S_HOLD);
   assign drive_lsb_nx = (state_nx == S_ARB_LSB) || (state_nx == S_HOLD);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= S_IDLE;
         pend_cnt       <= 2'd0;
         overflow       <= 1'b0;
         ack_valid_n_oe <= 1'b0;
         ack_id_oe      <= 2'b00;
         req            <= 1'b0;
         ack_done       <= 1'b0;
         timeout_err    <= 1'b0;
      end else begin
         state          <= state_nx;
         pend_cnt       <= pend_nx;
         overflow       <= overflow | ovf_set;
         ack_valid_n_oe <= drive_nx;
         ack_id_oe[1]   <= drive_nx & ~SOURCE_ID[1];
         ack_id_oe[0]   <= drive_lsb_nx & ~SOURCE_ID[0];
         req            <= (state_nx == S_HOLD);
         ack_done       <= deliver;
         timeout_err    <= tmo_hit;
      end
   end

endmodule

// File: tb/tb_ack_bus_requester.sv
// tb/tb_ack_bus_requester.sv - two requesters (ID 01, ID 10) on a modelled open-drain bus, directed and randomized checks
module tb_ack_bus_requester;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       pulse_a, pulse_b, ready_a, ready_b;
   logic       voe_a, voe_b, req_a, req_b, done_a, done_b;
   logic       ovf_a, ovf_b, tmo_a, tmo_b;
   logic [1:0] idoe_a, idoe_b, pend_a, pend_b;
   logic       valid_n_bus;
   logic [1:0] id_bus;

   int n_tests = 0;
   int n_fail  = 0;
   bit overlap_seen = 0;

   always #5 clk = ~clk;

   assign valid_n_bus = ~(voe_a | voe_b);
   assign id_bus      = ~(idoe_a | idoe_b);

   ack_bus_requester #(.SOURCE_ID(2'b01), .TIMEOUT_CYCLES(4)) u_a (
      .clk(clk), .rst_n(rst_n), .ack_pulse(pulse_a), .ack_valid_n_bus(valid_n_bus),
      .ack_id_bus(id_bus), .ack_ready(ready_a), .ack_valid_n_oe(voe_a), .ack_id_oe(idoe_a),
      .req(req_a), .ack_done(done_a), .pend_cnt(pend_a), .overflow(ovf_a), .timeout_err(tmo_a));

   ack_bus_requester #(.SOURCE_ID(2'b10), .TIMEOUT_CYCLES(4)) u_b (
      .clk(clk), .rst_n(rst_n), .ack_pulse(pulse_b), .ack_valid_n_bus(valid_n_bus),
      .ack_id_bus(id_bus), .ack_ready(ready_b), .ack_valid_n_oe(voe_b), .ack_id_oe(idoe_b),
      .req(req_b), .ack_done(done_b), .pend_cnt(pend_b), .overflow(ovf_b), .timeout_err(tmo_b));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (req_a && req_b) overlap_seen = 1;
   endtask

   task automatic wait_req(input bit which_b, input int budget, output bit found);
      found = 0;
      for (int i = 0; i < budget; i++) begin
         if (which_b ? req_b : req_a) begin
            found = 1;
            break;
         end
         tick();
      end
   endtask

   task automatic grant_b(input string tag);
      bit found;
      wait_req(1'b1, 40, found);
      check({tag, "_req_seen"}, found, 1);
      ready_b = 1;
      tick();
      ready_b = 0;
      check({tag, "_done"}, done_b, 1);
   endtask

   task automatic do_reset();
      rst_n = 0;
      tick();
      tick();
      rst_n = 1;
      tick();
   endtask

   function automatic void model_step(input int pm_in, input bit pls, input bit del,
                                      output int pm_out, output bit drop);
      drop   = 0;
      pm_out = pm_in;
      if (pls && !del) begin
         if (pm_in >= 3) drop = 1;
         else pm_out = pm_in + 1;
      end else if (!pls && del) begin
         pm_out = pm_in - 1;
      end
   endfunction

   initial begin
      bit found;
      int hold_cnt, tmo_cnt;
      int pm_a, pm_b, acc_a, acc_b, got_a, got_b;
      bit om_a, om_b, ed_a, ed_b, da, db, drop;
      bit pa, pb, ra, rb;

      rst_n = 0; pulse_a = 0; pulse_b = 0; ready_a = 0; ready_b = 0;
      #1;
      check("rst_voe", voe_b, 0);
      check("rst_idoe", idoe_b, 0);
      check("rst_req", req_b, 0);
      check("rst_pend", pend_b, 0);
      check("rst_done", done_b, 0);
      tick();
      rst_n = 1;
      tick();

      // solo delivery, grant on first HOLD cycle
      pulse_b = 1;
      tick();
      pulse_b = 0;
      check("solo_t1_voe", voe_b, 1);
      check("solo_t1_idoe", idoe_b, 2'b00);
      check("solo_t1_pend", pend_b, 1);
      tick();
      check("solo_t2_idoe", idoe_b, 2'b01);
      check("solo_t2_req", req_b, 0);
      tick();
      check("solo_t3_req", req_b, 1);
      check("solo_t3_bus", id_bus, 2'b10);
      ready_b = 1;
      tick();
      ready_b = 0;
      check("solo_t4_done", done_b, 1);
      check("solo_t4_voe", voe_b, 0);
      check("solo_t4_idoe", idoe_b, 2'b00);
      check("solo_t4_req", req_b, 0);
      check("solo_t4_pend", pend_b, 0);
      tick();
      check("solo_t5_done", done_b, 0);

      // contention: ID 01 beats ID 10
      pulse_a = 1; pulse_b = 1;
      tick();
      pulse_a = 0; pulse_b = 0;
      check("cont_t1_voe_a", voe_a, 1);
      check("cont_t1_voe_b", voe_b, 1);
      tick();
      check("cont_t2_voe_b", voe_b, 0);
      check("cont_t2_idoe_a", idoe_a, 2'b10);
      tick();
      check("cont_t3_req_a", req_a, 1);
      check("cont_t3_req_b", req_b, 0);
      ready_a = 1;
      tick();
      ready_a = 0;
      check("cont_done_a", done_a, 1);
      check("cont_pend_b", pend_b, 1);
      grant_b("cont_b");
      check("cont_pend_b_end", pend_b, 0);
      check("cont_no_overlap", overlap_seen, 0);

      // queue saturation and overflow
      pulse_b = 1;
      for (int i = 0; i < 4; i++) tick();
      pulse_b = 0;
      check("q_pend3", pend_b, 3);
      check("q_ovf", ovf_b, 1);
      for (int i = 0; i < 3; i++) grant_b("q_grant");
      check("q_pend0", pend_b, 0);
      check("q_ovf_sticky", ovf_b, 1);

      // async reset in HOLD
      pulse_b = 1;
      tick();
      pulse_b = 0;
      wait_req(1'b1, 40, found);
      check("rsth_req_seen", found, 1);
      #2 rst_n = 0;
      #1;
      check("rsth_voe", voe_b, 0);
      check("rsth_idoe", idoe_b, 0);
      check("rsth_req", req_b, 0);
      check("rsth_pend", pend_b, 0);
      check("rsth_ovf", ovf_b, 0);
      tick();
      rst_n = 1;
      tick();

      // pulse and delivery in the same cycle
      pulse_b = 1;
      tick();
      tick();
      pulse_b = 0;
      wait_req(1'b1, 40, found);
      check("pd_req_seen", found, 1);
      check("pd_pend_before", pend_b, 2);
      pulse_b = 1; ready_b = 1;
      tick();
      pulse_b = 0; ready_b = 0;
      check("pd_pend_after", pend_b, 2);
      check("pd_done", done_b, 1);
      grant_b("pd_drain1");
      grant_b("pd_drain2");
      check("pd_pend0", pend_b, 0);

      // HOLD without ready
      pulse_b = 1;
      tick();
      pulse_b = 0;
      wait_req(1'b1, 40, found);
      check("to_req_seen", found, 1);
`ifdef ACK_TIMEOUT_EN
      tick(); tick(); tick();
      check("to_hold4_req", req_b, 1);
      check("to_hold4_err", tmo_b, 0);
      tick();
      check("to_err", tmo_b, 1);
      check("to_req_drop", req_b, 0);
      check("to_pend_kept", pend_b, 1);
      tick();
      check("to_err_pulse", tmo_b, 0);
      grant_b("to_retry");
`else
      hold_cnt = 0; tmo_cnt = 0;
      for (int i = 0; i < 1000; i++) begin
         tick();
         if (req_b) hold_cnt++;
         if (tmo_b) tmo_cnt++;
      end
      check("hold_1000", hold_cnt, 1000);
      check("hold_no_tmo", tmo_cnt, 0);
      ready_b = 1;
      tick();
      ready_b = 0;
      check("hold_done", done_b, 1);
`endif
      check("to_pend0", pend_b, 0);

      // randomized traffic against a queue-count model
      do_reset();
      pm_a = 0; pm_b = 0; om_a = 0; om_b = 0; ed_a = 0; ed_b = 0;
      acc_a = 0; acc_b = 0; got_a = 0; got_b = 0;
      overlap_seen = 0;
      for (int cyc = 0; cyc < 2300; cyc++) begin
         check("rnd_pend_a", pend_a, pm_a);
         check("rnd_pend_b", pend_b, pm_b);
         check("rnd_ovf_a", ovf_a, om_a);
         check("rnd_ovf_b", ovf_b, om_b);
         check("rnd_done_a", done_a, ed_a);
         check("rnd_done_b", done_b, ed_b);
         if (done_a) got_a++;
         if (done_b) got_b++;
         if (cyc < 2000) begin
            pa = ($urandom_range(0, 5) == 0);
            pb = ($urandom_range(0, 5) == 0);
            ra = $urandom_range(0, 1);
            rb = $urandom_range(0, 1);
         end else begin
            pa = 0; pb = 0; ra = 1; rb = 1;
         end
         da = ra && req_a;
         db = rb && req_b;
         model_step(pm_a, pa, da, pm_a, drop);
         if (drop) om_a = 1;
         else if (pa) acc_a++;
         model_step(pm_b, pb, db, pm_b, drop);
         if (drop) om_b = 1;
         else if (pb) acc_b++;
         ed_a = da; ed_b = db;
         pulse_a = pa; pulse_b = pb; ready_a = ra; ready_b = rb;
         tick();
      end
      pulse_a = 0; pulse_b = 0; ready_a = 0; ready_b = 0;
      check("rnd_drained_a", pend_a, 0);
      check("rnd_drained_b", pend_b, 0);
      check("rnd_count_a", got_a, acc_a);
      check("rnd_count_b", got_b, acc_b);
      check("rnd_no_overlap", overlap_seen, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
